// File: rtl/arr_port_arbiter.sv
// Round-robin arbiter that shares one single-port array among NREQ requesters.
// Supports locked multi-cycle ownership with a bounded hold time.
module arr_port_arbiter #(
    parameter int NREQ     = 2,
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int DEPTH    = 1000,
    parameter int LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic signed [DW-1:0] rdata,
    output logic                 arrWEnable,
    output logic [AW-1:0]        arrAddr,
    output logic signed [DW-1:0] arrWData,
    input  logic signed [DW-1:0] arrRData,
    output logic                 lock_abort,
    output logic                 addr_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(LOCK_MAX);
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_MAX - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [PW-1:0]   owner, owner_next;
    logic [HW-1:0]   hold, hold_next;
    logic            abort_next;

    logic [PW-1:0]   winner;
    logic [PW-1:0]   scan;
    logic            found;
    logic            granted;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;
    logic            in_range;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Winner selection: the owner alone while locked, else circular scan from ptr.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        scan   = ptr;
        if (state == OWNED) begin
            winner = owner;
            found  = req[owner];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[scan]) begin
                    winner = scan;
                    found  = 1'b1;
                end
                scan = next_idx(scan);
            end
        end
    end

    always_comb begin
        sel_addr   = addr[int'(winner)*AW +: AW];
        sel_wdata  = wdata[int'(winner)*DW +: DW];
        sel_we     = we[winner];
        in_range   = {1'b0, sel_addr} < DEPTH_LIM;
        granted    = found && !rst;
        gnt        = '0;
        if (granted) begin
            gnt[winner] = 1'b1;
        end
        arrAddr    = granted ? sel_addr : '0;
        arrWData   = granted ? sel_wdata : '0;
        arrWEnable = granted && sel_we && in_range;
    end

    assign rdata = arrRData;

    // Ownership bookkeeping; a lock held to LOCK_MAX cycles is broken by force.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        hold_next  = hold;
        abort_next = 1'b0;
        case (state)
            IDLE: begin
                if (granted) begin
                    ptr_next = next_idx(winner);
                    if (lock[winner]) begin
                        owner_next = winner;
                        hold_next  = HW'(1);
                        state_next = OWNED;
                    end
                end
            end
            OWNED: begin
                hold_next = hold + 1'b1;
                if (!lock[owner]) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else if (hold == HOLD_LAST) begin
                    state_next = IDLE;
                    hold_next  = '0;
                    abort_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            hold       <= '0;
            lock_abort <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            owner      <= owner_next;
            hold       <= hold_next;
            lock_abort <= abort_next;
            addr_err   <= granted && !in_range;
        end
    end

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Self-checking bench for arr_port_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of arbitration and array contents.
module tb_arr_port_arbiter;

    localparam int NREQ     = 2;
    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int DEPTH    = 1000;
    localparam int LOCK_MAX = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req, lock, we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [DW-1:0]        rdata;
    logic                 arrWEnable;
    logic [AW-1:0]        arrAddr;
    logic [DW-1:0]        arrWData;
    logic [DW-1:0]        arrRData;
    logic                 lock_abort, addr_err;

    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] shadow [DEPTH];

    int m_ptr, m_owner, m_cnt;
    bit m_abort_pend, m_err_pend;

    int test_count = 0;
    int fail_count = 0;

    logic [NREQ-1:0] last_gnt;
    logic [DW-1:0]   last_rdata;
    logic            last_we, last_abort, last_err;

    bit            pend [NREQ];
    logic [DW-1:0] saved_rdata;
    int            nbad;
    logic [1:0]    rr_exp [4];

    arr_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rdata(rdata),
        .arrWEnable(arrWEnable), .arrAddr(arrAddr), .arrWData(arrWData),
        .arrRData(arrRData), .lock_abort(lock_abort), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Behavioural single-port array: combinational read, write at posedge.
    assign arrRData = (int'(arrAddr) < DEPTH) ? mem[arrAddr] : '0;
    always @(posedge clk) begin
        if (arrWEnable && int'(arrAddr) < DEPTH) mem[arrAddr] <= arrWData;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0; m_owner = -1; m_cnt = 0; m_abort_pend = 0; m_err_pend = 0;
    endtask

    task automatic setReq(input int i, input bit r, input bit l, input bit w,
                          input int a, input logic [DW-1:0] d);
        req[i] = r;
        lock[i] = l;
        we[i] = w;
        addr[i*AW +: AW] = AW'(a);
        wdata[i*DW +: DW] = d;
    endtask

    // One clock cycle: inputs already driven; compare mid-cycle, then advance the model.
    task automatic applyStimulus();
        int w;
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        bit              ewe;
        @(negedge clk);
        w = -1;
        if (m_owner >= 0) begin
            if (req[m_owner]) w = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (w < 0 && req[c]) w = c;
            end
        end
        eg = '0; ea = '0; ed = '0; ewe = 0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ea  = addr[w*AW +: AW];
            ed  = wdata[w*DW +: DW];
            ewe = we[w] && (int'(ea) < DEPTH);
        end
        checkOutput("gnt", gnt, eg);
        checkOutput("arrWEnable", arrWEnable, ewe);
        checkOutput("arrAddr", arrAddr, ea);
        checkOutput("arrWData", arrWData, ed);
        checkOutput("lock_abort", lock_abort, m_abort_pend);
        checkOutput("addr_err", addr_err, m_err_pend);
        if (w >= 0 && !we[w] && int'(ea) < DEPTH) checkOutput("rdata", rdata, shadow[ea]);
        last_gnt = gnt; last_rdata = rdata; last_we = arrWEnable;
        last_abort = lock_abort; last_err = addr_err;

        m_err_pend = (w >= 0) && (int'(ea) >= DEPTH);
        m_abort_pend = 0;
        if (m_owner < 0) begin
            if (w >= 0) begin
                m_ptr = (w + 1) % NREQ;
                if (lock[w]) begin
                    m_owner = w;
                    m_cnt = 1;
                end
            end
        end else begin
            m_cnt++;
            if (!lock[m_owner]) begin
                m_owner = -1;
            end else if (m_cnt == LOCK_MAX) begin
                m_owner = -1;
                m_abort_pend = 1;
            end
        end
        if (ewe) shadow[ea] = ed;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'(i);
            shadow[i] = DW'(i);
        end
        modelReset();
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        req = 2'b11; we = 2'b11;
        #7;
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_we", arrWEnable, 0);
        checkOutput("rst_abort", lock_abort, 0);
        checkOutput("rst_err", addr_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0; we = '0;

        // Round-robin on two always-requesting readers.
        setReq(0, 1, 0, 0, 11, 0);
        setReq(1, 1, 0, 0, 12, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("rr_seq", last_gnt, rr_exp[i]);
        end

        setReq(1, 0, 0, 0, 0, 0);
        setReq(0, 1, 0, 0, 5, 0);
        applyStimulus();
        checkOutput("single_gnt", last_gnt, 2'b01);
        checkOutput("single_rdata", last_rdata, 5);

        // Locked read-modify-write on address 7 while requester 0 waits.
        setReq(0, 1, 0, 0, 3, 0);
        setReq(1, 1, 1, 0, 7, 0);
        applyStimulus();
        checkOutput("rmw_rd_gnt", last_gnt, 2'b10);
        checkOutput("rmw_rd_data", last_rdata, 7);
        saved_rdata = last_rdata;
        setReq(1, 1, 0, 1, 7, saved_rdata + 100);
        applyStimulus();
        checkOutput("rmw_wr_gnt", last_gnt, 2'b10);
        setReq(1, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("rmw_after_gnt", last_gnt, 2'b01);
        checkOutput("rmw_mem7", mem[7], 107);

        // Forced release after LOCK_MAX owned cycles.
        setReq(0, 0, 0, 0, 0, 0);
        setReq(1, 1, 0, 0, 9, 0);
        applyStimulus();
        setReq(0, 1, 1, 0, 4, 0);
        for (int c = 1; c <= LOCK_MAX + 1; c++) begin
            applyStimulus();
            if (c <= LOCK_MAX) begin
                checkOutput("lock_hold_gnt", last_gnt, 2'b01);
                checkOutput("lock_hold_abort", last_abort, 0);
            end else begin
                checkOutput("abort_gnt", last_gnt, 2'b10);
                checkOutput("abort_pulse", last_abort, 1);
            end
        end
        setReq(0, 0, 0, 0, 0, 0);
        setReq(1, 0, 0, 0, 0, 0);
        applyStimulus();

        // Out-of-range write must not touch the array.
        setReq(0, 1, 0, 1, 1000, 32'hDEAD);
        applyStimulus();
        checkOutput("oor_gnt", last_gnt, 2'b01);
        checkOutput("oor_we", last_we, 0);
        setReq(0, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("oor_err", last_err, 1);

        // Async reset while owned with a write in flight.
        setReq(0, 1, 1, 1, 20, 55);
        applyStimulus();
        setReq(0, 1, 1, 1, 21, 77);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_gnt", gnt, 0);
        checkOutput("midrst_we", arrWEnable, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput("midrst_mem21", mem[21], 21);
        checkOutput("midrst_mem20", mem[20], 55);
        setReq(0, 1, 0, 0, 30, 0);
        setReq(1, 1, 0, 0, 31, 0);
        applyStimulus();
        checkOutput("post_rst_gnt", last_gnt, 2'b01);
        setReq(0, 0, 0, 0, 0, 0);
        setReq(1, 0, 0, 0, 0, 0);
        applyStimulus();

        // Randomized traffic: requesters hold their payload until granted.
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    setReq(i, 1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 15) == 0) ? int'($urandom_range(DEPTH, 1023))
                                                        : int'($urandom_range(0, 63)),
                           $urandom);
                end else begin
                    req[i]  = pend[i];
                    lock[i] = $urandom_range(0, 2) != 0;
                end
            end
            applyStimulus();
            for (int i = 0; i < NREQ; i++) begin
                if (last_gnt[i]) pend[i] = 0;
            end
        end

        nbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== shadow[i]) nbad++;
        end
        checkOutput("mem_final", nbad, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
